// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and width helpers for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Burst counter must be able to hold MAX_BURST itself for a moment.
  function automatic int burst_width(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - first set bit of a valid vector searching upward from a start index with wrap
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(start) + k) % N);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-bounded arbiter sharing one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  wr_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = burst_width(MAX_BURST);

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  gid_q, gid_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];

  logic          granted;
  logic          cur_valid;
  logic          xfer;
  logic          last_beat;
  logic          release_now;
  logic [IW-1:0] next_id;
  logic [IW-1:0] pick_start;
  logic          pick_found;
  logic [IW-1:0] pick_idx;

  assign granted     = (state_q == ARB_GRANT);
  assign cur_valid   = req_valid[gid_q];
  assign xfer        = granted && !rst && !fifo_full && cur_valid;
  assign last_beat   = (burst_q == BW'(MAX_BURST - 1));
  assign release_now = granted && (!cur_valid || (xfer && last_beat));
  assign next_id     = (gid_q == IW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
  // On release the search starts just past the holder, so it wins only when alone.
  assign pick_start  = granted ? next_id : ptr_q;

  fifo_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .valid (req_valid),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = xfer;
    fifo_data_in = '0;
    grant_valid  = granted;
    grant_id     = gid_q;
    if (granted && !rst && !fifo_full) begin
      req_ready[gid_q] = 1'b1;
    end
    if (xfer) begin
      fifo_data_in = req_data[int'(gid_q)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_GRANT;
          gid_d   = pick_idx;
          burst_d = '0;
        end
      end
      ARB_GRANT: begin
        if (xfer) begin
          burst_d = burst_q + 1'b1;
        end
        if (release_now) begin
          ptr_d   = next_id;
          burst_d = '0;
          if (pick_found) begin
            state_d = ARB_GRANT;
            gid_d   = pick_idx;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (xfer) begin
      cnt_q[gid_q] <= cnt_q[gid_q] + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt_out
    assign wr_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter against a queue-based reference model
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic [N*CW-1:0] wr_count;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .wr_count     (wr_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] q [N][$];
  bit         en [N];
  logic [7:0] wlog [$];
  int         wcyc [$];
  logic [N-1:0] obs_ready;

  int m_busy, m_gid, m_ptr, m_burst;
  int m_cnt [N];

  logic [N-1:0]    e_ready;
  logic            e_wr;
  logic [7:0]      e_data;
  logic            e_gv;
  logic [1:0]      e_gid;
  logic [N*CW-1:0] e_cnt;

  function automatic void m_pick(input int start);
    m_busy = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (req_valid[j]) begin
        m_busy  = 1;
        m_gid   = j;
        m_burst = 0;
        return;
      end
    end
  endfunction

  function automatic void model_eval();
    e_ready = '0;
    e_wr    = 1'b0;
    e_data  = '0;
    e_gv    = (m_busy != 0);
    e_gid   = 2'(m_gid);
    for (int i = 0; i < N; i++) e_cnt[i*CW +: CW] = m_cnt[i][CW-1:0];
    if (!rst && m_busy != 0 && !fifo_full) begin
      e_ready[m_gid] = 1'b1;
      if (req_valid[m_gid]) begin
        e_wr   = 1'b1;
        e_data = q[m_gid][0];
      end
    end
  endfunction

  function automatic void model_update();
    bit rel;
    if (rst) begin
      m_busy = 0; m_gid = 0; m_ptr = 0; m_burst = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      return;
    end
    if (m_busy == 0) begin
      m_pick(m_ptr);
    end else begin
      rel = !req_valid[m_gid];
      if (e_wr) begin
        m_cnt[m_gid] = (m_cnt[m_gid] + 1) % (1 << CW);
        m_burst++;
        if (m_burst == MB) rel = 1;
      end
      if (rel) begin
        m_ptr = (m_gid + 1) % N;
        m_pick(m_ptr);
      end
    end
  endfunction

  task automatic pre();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (q[i].size() > 0);
      req_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
    #1;
    model_eval();
  endtask

  task automatic post();
    obs_ready = req_ready;
    if (fifo_wr_en === 1'b1) begin
      wlog.push_back(fifo_data_in);
      wcyc.push_back(cyc);
    end
    @(posedge clk);
    for (int i = 0; i < N; i++)
      if (req_valid[i] && obs_ready[i]) void'(q[i].pop_front());
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      en[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    clear_reqs();
    fifo_full = 1'b0;
    rst = 1'b1;
    pre();
    post();
    rst = 1'b0;
    wlog.delete();
    wcyc.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b1;
      q[i].push_back(8'($urandom));
    end
    pre();
    post();
    repeat (2) begin
      pre();
      n_checks++;
      if ({req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs got=%h want=0",
                 {req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count});
      end
      post();
    end
    rst = 1'b0;
    clear_reqs();
  endtask

  task automatic test_single();
    logic [23:0] got_d, got_c;
    do_reset();
    q[1].push_back(8'hA1); q[1].push_back(8'hA2); q[1].push_back(8'hA3);
    en[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      pre();
      n_checks++;
      if ({req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count} !==
          {e_ready, e_wr, e_data, e_gv, e_gid, e_cnt}) begin
        n_fail++;
        $display("FAIL single_model cyc=%0d got=%h want=%h", c,
                 {req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count},
                 {e_ready, e_wr, e_data, e_gv, e_gid, e_cnt});
      end
      if (c == 1) begin
        n_checks++;
        if ({grant_valid, grant_id} !== 3'b1_01) begin
          n_fail++;
          $display("FAIL single_grant got=%b want=101", {grant_valid, grant_id});
        end
      end
      post();
    end
    got_d = (wlog.size() == 3) ? {wlog[0], wlog[1], wlog[2]} : 'x;
    got_c = (wcyc.size() == 3) ? {8'(wcyc[0]), 8'(wcyc[1]), 8'(wcyc[2])} : 'x;
    n_checks++;
    if (got_d !== 24'hA1A2A3) begin
      n_fail++;
      $display("FAIL single_words got=%h want=a1a2a3", got_d);
    end
    n_checks++;
    if (got_c !== 24'h010203) begin
      n_fail++;
      $display("FAIL single_cycles got=%h want=010203", got_c);
    end
    n_checks++;
    if (wr_count[CW +: CW] !== 16'd3) begin
      n_fail++;
      $display("FAIL single_count got=%0d want=3", wr_count[CW +: CW]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_w;
    do_reset();
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b1;
      for (int k = 0; k < 8; k++) q[i].push_back({4'(i), 4'(k)});
    end
    for (int c = 0; c < 18; c++) begin
      pre();
      n_checks++;
      if ({req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count} !==
          {e_ready, e_wr, e_data, e_gv, e_gid, e_cnt}) begin
        n_fail++;
        $display("FAIL b2b_model cyc=%0d got=%h want=%h", c,
                 {req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count},
                 {e_ready, e_wr, e_data, e_gv, e_gid, e_cnt});
      end
      post();
    end
    for (int k = 0; k < 17; k++) begin
      exp_w = {4'((k / 4) % 4), 4'((k / 16) * 4 + k % 4)};
      n_checks++;
      if (k >= wlog.size() || wlog[k] !== exp_w || wcyc[k] != k + 1) begin
        n_fail++;
        $display("FAIL b2b_order idx=%0d got=%h@%0d want=%h@%0d", k,
                 (k < wlog.size()) ? wlog[k] : 8'hxx, (k < wcyc.size()) ? wcyc[k] : -1,
                 exp_w, k + 1);
      end
    end
    clear_reqs();
  endtask

  task automatic test_fifo_full();
    int fc = 0;
    logic [31:0] got_d, got_c;
    do_reset();
    for (int k = 0; k < 4; k++) q[2].push_back(8'h20 + 8'(k));
    en[2] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      fifo_full = (wlog.size() == 2 && fc < 5);
      if (fifo_full) fc++;
      pre();
      n_checks++;
      if ({req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count} !==
          {e_ready, e_wr, e_data, e_gv, e_gid, e_cnt}) begin
        n_fail++;
        $display("FAIL full_model cyc=%0d got=%h want=%h", c,
                 {req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count},
                 {e_ready, e_wr, e_data, e_gv, e_gid, e_cnt});
      end
      if (fifo_full) begin
        n_checks++;
        if ({req_ready, fifo_wr_en, grant_valid, grant_id} !== 8'b0000_0_1_10) begin
          n_fail++;
          $display("FAIL full_hold cyc=%0d got=%b want=00000110", c,
                   {req_ready, fifo_wr_en, grant_valid, grant_id});
        end
      end
      post();
    end
    fifo_full = 1'b0;
    got_d = (wlog.size() == 4) ? {wlog[0], wlog[1], wlog[2], wlog[3]} : 'x;
    got_c = (wcyc.size() == 4) ? {8'(wcyc[0]), 8'(wcyc[1]), 8'(wcyc[2]), 8'(wcyc[3])} : 'x;
    n_checks++;
    if (got_d !== 32'h20212223 || got_c !== 32'h01020809) begin
      n_fail++;
      $display("FAIL full_resume got=%h@%h want=20212223@01020809", got_d, got_c);
    end
    n_checks++;
    if (wr_count[2*CW +: CW] !== 16'd4) begin
      n_fail++;
      $display("FAIL full_count got=%0d want=4", wr_count[2*CW +: CW]);
    end
    clear_reqs();
  endtask

  task automatic test_drop();
    logic [55:0] got_d;
    do_reset();
    q[0].push_back(8'h01);
    for (int k = 0; k < 4; k++) q[3].push_back(8'h30 + 8'(k));
    en[0] = 1'b1;
    en[3] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) begin
        q[0].push_back(8'h02);
        q[0].push_back(8'h03);
      end
      pre();
      n_checks++;
      if ({req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count} !==
          {e_ready, e_wr, e_data, e_gv, e_gid, e_cnt}) begin
        n_fail++;
        $display("FAIL drop_model cyc=%0d got=%h want=%h", c,
                 {req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count},
                 {e_ready, e_wr, e_data, e_gv, e_gid, e_cnt});
      end
      if (c == 3) begin
        n_checks++;
        if ({grant_valid, grant_id} !== 3'b1_11) begin
          n_fail++;
          $display("FAIL drop_regrant got=%b want=111", {grant_valid, grant_id});
        end
      end
      post();
    end
    got_d = (wlog.size() == 7) ?
            {wlog[0], wlog[1], wlog[2], wlog[3], wlog[4], wlog[5], wlog[6]} : 'x;
    n_checks++;
    if (got_d !== 56'h01303132330203) begin
      n_fail++;
      $display("FAIL drop_order got=%h want=01303132330203", got_d);
    end
    clear_reqs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) q[2].push_back(8'h40 + 8'(k));
    en[2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) rst = 1'b1;
      if (c == 4) begin
        rst = 1'b0;
        q[1].push_back(8'h51);
        q[3].push_back(8'h53);
        en[1] = 1'b1;
        en[3] = 1'b1;
      end
      pre();
      n_checks++;
      if ({req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count} !==
          {e_ready, e_wr, e_data, e_gv, e_gid, e_cnt}) begin
        n_fail++;
        $display("FAIL rstmid_model cyc=%0d got=%h want=%h", c,
                 {req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count},
                 {e_ready, e_wr, e_data, e_gv, e_gid, e_cnt});
      end
      if (c == 3) begin
        n_checks++;
        if ({req_ready, fifo_wr_en, fifo_data_in} !== 13'h0) begin
          n_fail++;
          $display("FAIL rstmid_block got=%h want=0", {req_ready, fifo_wr_en, fifo_data_in});
        end
      end
      if (c == 4) begin
        n_checks++;
        if (grant_valid !== 1'b0 || wr_count !== '0) begin
          n_fail++;
          $display("FAIL rstmid_cleared got=%b/%h want=0/0", grant_valid, wr_count);
        end
      end
      if (c == 5) begin
        n_checks++;
        if ({grant_valid, grant_id} !== 3'b1_01) begin
          n_fail++;
          $display("FAIL rstmid_restart got=%b want=101", {grant_valid, grant_id});
        end
      end
      post();
    end
    clear_reqs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      fifo_full = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 3 && $urandom_range(0, 2) == 0) q[i].push_back(8'($urandom));
        en[i] = ($urandom_range(0, 7) != 0);
      end
      pre();
      n_checks++;
      if ({req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count} !==
          {e_ready, e_wr, e_data, e_gv, e_gid, e_cnt}) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d got=%h want=%h", c,
                 {req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count},
                 {e_ready, e_wr, e_data, e_gv, e_gid, e_cnt});
      end
      n_checks++;
      if ($countones(req_ready) > 1 || (fifo_wr_en && fifo_full)) begin
        n_fail++;
        $display("FAIL random_safety cyc=%0d ready=%b wr_en=%b full=%b want onehot0/no write when full",
                 c, req_ready, fifo_wr_en, fifo_full);
      end
      post();
    end
    rst = 1'b0;
    fifo_full = 1'b0;
    clear_reqs();
  endtask

  initial begin
    rst       = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    m_busy = 0; m_gid = 0; m_ptr = 0; m_burst = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
